// File: rtl/cpu_mon_pkg.sv
// Shared definitions for the multi-core run monitor: FSM state encodings,
// default halt instruction and the core-index width helper.
package cpu_mon_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;

  function automatic int unsigned core_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/core_halt_counter.sv
// Per-core sticky halt detector with a saturating run-cycle counter.
module core_halt_counter
  import cpu_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      inst,
  output logic             halted,
  output logic             halt_now,
  output logic [CNT_W-1:0] count
);

  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halt_hit;

  always_comb begin
    halted_d = halted_q;
    count_d  = count_q;
    halt_hit = run && !halted_q && (inst == HALT_WORD);
    if (clear) begin
      halted_d = 1'b0;
      count_d  = '0;
    end else if (halt_hit) begin
      halted_d = 1'b1;
    end else if (run && !halted_q && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Includes a halt seen this cycle so the FSM can leave RUN on the same edge.
  assign halt_now = halted_q | halt_hit;
  assign halted   = halted_q;
  assign count    = count_q;

endmodule

// File: rtl/multi_core_run_monitor.sv
// Run/halt monitor for NUM_CORES cores with watchdog and a valid/ready
// data-memory dump engine that starts once every core has halted.
module multi_core_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 5,
  parameter int unsigned DUMP_DEPTH   = 128,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned CORE_W       = core_w(NUM_CORES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [32*NUM_CORES-1:0]    core_inst,
  output logic                       mem_rd_en,
  output logic [CORE_W-1:0]          mem_rd_core,
  output logic [31:0]                mem_rd_addr,
  input  logic [63:0]                mem_rd_data,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [63:0]                dump_data,
  output logic [CORE_W-1:0]          dump_core,
  output logic [31:0]                dump_addr,
  output logic [CNT_W*NUM_CORES-1:0] cycle_count,
  output logic [NUM_CORES-1:0]       halted,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout
);

  logic [2:0]        state_q, state_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       fl_q, fl_d;
  logic [CORE_W-1:0] core_q, core_d;
  logic [31:0]       addr_q, addr_d;
  logic              dv_q, dv_d;
  logic [63:0]       dd_q, dd_d;
  logic [CORE_W-1:0] dc_q, dc_d;
  logic [31:0]       da_q, da_d;

  logic                 accept;
  logic                 run;
  logic [NUM_CORES-1:0] halt_now;
  logic                 all_halt;

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign run    = (state_q == ST_RUN);

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    core_halt_counter #(
      .CNT_W     (CNT_W),
      .HALT_WORD (HALT_WORD)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .run      (run),
      .inst     (core_inst[32*c +: 32]),
      .halted   (halted[c]),
      .halt_now (halt_now[c]),
      .count    (cycle_count[CNT_W*c +: CNT_W])
    );
  end

  assign all_halt = &halt_now;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    fl_d    = fl_q;
    core_d  = core_q;
    addr_d  = addr_q;
    dv_d    = dv_q;
    dd_d    = dd_q;
    dc_d    = dc_q;
    da_d    = da_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_RUN;
          wd_d    = '0;
        end
      end
      ST_RUN: begin
        wd_d = wd_q + 32'd1;
        // A final halt on the watchdog's last cycle takes precedence.
        if (all_halt) begin
          state_d = (FLUSH_CYCLES == 0) ? ST_RD : ST_FLUSH;
          fl_d    = '0;
          core_d  = '0;
          addr_d  = '0;
        end else if (wd_q == 32'(MAX_CYCLES - 1)) begin
          state_d = ST_ERR;
        end
      end
      ST_FLUSH: begin
        if (fl_q == 32'(FLUSH_CYCLES - 1)) state_d = ST_RD;
        else                               fl_d    = fl_q + 32'd1;
      end
      ST_RD: state_d = ST_WAIT;
      ST_WAIT: begin
        dd_d    = mem_rd_data;
        dc_d    = core_q;
        da_d    = addr_q;
        dv_d    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (dump_ready) begin
          dv_d = 1'b0;
          if (addr_q == 32'(DUMP_DEPTH - 1)) begin
            addr_d = '0;
            if (core_q == CORE_W'(NUM_CORES - 1)) begin
              state_d = ST_DONE;
            end else begin
              core_d  = core_q + CORE_W'(1);
              state_d = ST_RD;
            end
          end else begin
            addr_d  = addr_q + 32'd1;
            state_d = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      fl_q    <= '0;
      core_q  <= '0;
      addr_q  <= '0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
      dc_q    <= '0;
      da_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      fl_q    <= fl_d;
      core_q  <= core_d;
      addr_q  <= addr_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
      dc_q    <= dc_d;
      da_q    <= da_d;
    end
  end

  assign mem_rd_en   = (state_q == ST_RD);
  assign mem_rd_core = mem_rd_en ? core_q : '0;
  assign mem_rd_addr = mem_rd_en ? addr_q : '0;
  assign dump_valid  = dv_q;
  assign dump_data   = dd_q;
  assign dump_core   = dc_q;
  assign dump_addr   = da_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_RD) ||
                       (state_q == ST_WAIT) || (state_q == ST_HOLD);
  assign done        = (state_q == ST_DONE);
  assign timeout     = (state_q == ST_ERR);

endmodule

// File: tb/tb_multi_core_run_monitor.sv
// Scoreboard bench for multi_core_run_monitor: 4 cores, 4-word dump, 50-cycle watchdog.
module tb_multi_core_run_monitor;
  import cpu_mon_pkg::*;

  localparam int unsigned NC   = 4;
  localparam int unsigned DD   = 4;
  localparam int unsigned FL   = 5;
  localparam int unsigned MC   = 50;
  localparam int unsigned CNTW = 32;
  localparam int unsigned CW   = 2;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [32*NC-1:0]     core_inst;
  logic                 mem_rd_en;
  logic [CW-1:0]        mem_rd_core;
  logic [31:0]          mem_rd_addr;
  logic [63:0]          mem_rd_data;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [63:0]          dump_data;
  logic [CW-1:0]        dump_core;
  logic [31:0]          dump_addr;
  logic [CNTW*NC-1:0]   cycle_count;
  logic [NC-1:0]        halted;
  logic                 busy;
  logic                 done;
  logic                 timeout;

  multi_core_run_monitor #(
    .NUM_CORES    (NC),
    .HALT_WORD    (32'h0000_0000),
    .FLUSH_CYCLES (FL),
    .DUMP_DEPTH   (DD),
    .CNT_W        (CNTW),
    .MAX_CYCLES   (MC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .core_inst   (core_inst),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_core (mem_rd_core),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_core   (dump_core),
    .dump_addr   (dump_addr),
    .cycle_count (cycle_count),
    .halted      (halted),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [31:0]   a;
    logic [63:0]   d;
  } exp_t;

  exp_t sb_q[$];
  int   total, bad;
  int   rdcnt, acc_cnt, stall_cnt, stall_left;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dmem(input int unsigned c, input int unsigned a);
    return {16'hD00D, 8'(c), 8'(a), 32'(a * 32'h0101_0003 + c * 32'h0711_0000 + 32'h9E37)};
  endfunction

  // Data memory: response valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? dmem(mem_rd_core, mem_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: counts reads, checks hold stability and pops the scoreboard on each handshake.
  initial begin
    logic          prev_v, prev_r;
    logic [63:0]   prev_d;
    logic [CW-1:0] prev_c;
    logic [31:0]   prev_a;
    exp_t          e;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; prev_c = '0; prev_a = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_v = 1'b0;
      end else begin
        if (mem_rd_en) rdcnt++;
        if (dump_valid && !dump_ready) stall_cnt++;
        if (prev_v && !prev_r) begin
          chk("hold_valid", dump_valid, 1);
          chk("hold_data", dump_data, prev_d);
          chk("hold_core", dump_core, prev_c);
          chk("hold_addr", dump_addr, prev_a);
          chk("hold_no_read", mem_rd_en, 0);
        end
        if (dump_valid && dump_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got core %0d addr %0d, expected no word", dump_core, dump_addr);
          end else begin
            e = sb_q.pop_front();
            chk("sb_core", dump_core, e.c);
            chk("sb_addr", dump_addr, e.a);
            chk("sb_data", dump_data, e.d);
          end
          acc_cnt++;
        end
        prev_v = dump_valid; prev_r = dump_ready;
        prev_d = dump_data;  prev_c = dump_core; prev_a = dump_addr;
      end
    end
  end

  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && dump_valid && acc_cnt == 2) begin
        dump_ready = 1'b0;
        stall_left--;
      end else begin
        dump_ready = 1'b1;
      end
    end
  end

  task automatic push_dump;
    for (int unsigned c = 0; c < NC; c++)
      for (int unsigned a = 0; a < DD; a++)
        sb_q.push_back('{CW'(c), a, dmem(c, a)});
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Leaves the bench inside RUN cycle ncyc-1; h<0 means the core never halts.
  task automatic drive_run(input int h0, input int h1, input int h2, input int h3, input int ncyc);
    int h[4];
    h = '{h0, h1, h2, h3};
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < 4; c++)
        core_inst[32*c +: 32] = (h[c] >= 0 && k >= h[c]) ? 32'h0000_0000 : (32'h1300_0000 + 32'(k));
      if (k < ncyc - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic rd_latency(input string nm);
    int n;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); @(negedge clk);
      if (mem_rd_en) begin
        n = i;
        break;
      end
    end
    chk(nm, n, 6);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(nm, done, 1);
    chk({nm, "_sb_left"}, sb_q.size(), 0);
    chk({nm, "_reads"}, rdcnt, NC * DD);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_timeout"}, timeout, 0);
  endtask

  task automatic chk_counts(input string nm, input int e0, input int e1, input int e2, input int e3,
                            input logic [3:0] eh);
    chk({nm, "_cnt0"}, cycle_count[0 +: 32], e0);
    chk({nm, "_cnt1"}, cycle_count[32 +: 32], e1);
    chk({nm, "_cnt2"}, cycle_count[64 +: 32], e2);
    chk({nm, "_cnt3"}, cycle_count[96 +: 32], e3);
    chk({nm, "_halted"}, halted, eh);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_rd_en"}, mem_rd_en, 0);
    chk({nm, "_rd_core"}, mem_rd_core, 0);
    chk({nm, "_rd_addr"}, mem_rd_addr, 0);
    chk({nm, "_valid"}, dump_valid, 0);
    chk({nm, "_data"}, dump_data, 0);
    chk({nm, "_dcore"}, dump_core, 0);
    chk({nm, "_daddr"}, dump_addr, 0);
    chk({nm, "_counts"}, |cycle_count, 0);
    chk({nm, "_halted"}, halted, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_timeout"}, timeout, 0);
  endtask

  task automatic new_run;
    rdcnt = 0; acc_cnt = 0; stall_cnt = 0;
  endtask

  initial begin
    total = 0; bad = 0; stall_left = 0;
    new_run();
    reset = 1'b0; start = 1'b0; core_inst = '1;
    repeat (3) @(posedge clk);
    #2 chk_idle("por");
    @(negedge clk) reset = 1'b1;

    // A: all cores halt on RUN cycle 12
    new_run(); push_dump();
    pulse_start();
    chk("A_busy_run", busy, 1);
    drive_run(12, 12, 12, 12, 13);
    rd_latency("A_rd_latency");
    wait_done("A_done");
    chk_counts("A", 12, 12, 12, 12, 4'hF);

    // B: staggered halts, stall on word 2
    new_run(); push_dump(); stall_left = 10;
    pulse_start();
    drive_run(3, 9, 9, 20, 21);
    rd_latency("B_rd_latency");
    wait_done("B_done");
    chk_counts("B", 3, 9, 9, 20, 4'hF);
    chk("B_stall_cycles", stall_cnt, 10);

    // C: final halt on the watchdog's last cycle still dumps
    new_run(); push_dump();
    pulse_start();
    drive_run(49, 49, 49, 49, 50);
    rd_latency("C_rd_latency");
    wait_done("C_done");
    chk_counts("C", 49, 49, 49, 49, 4'hF);

    // D: core 1 hangs, watchdog fires after 50 RUN cycles
    new_run();
    pulse_start();
    drive_run(5, -1, 5, 5, 50);
    chk("D_no_early_timeout", timeout, 0);
    @(posedge clk); #1;
    chk("D_timeout", timeout, 1);
    chk("D_busy", busy, 0);
    chk("D_done", done, 0);
    chk_counts("D", 5, 50, 5, 5, 4'b1101);
    repeat (5) @(negedge clk);
    chk("D_no_reads", rdcnt, 0);
    chk("D_no_valid", dump_valid, 0);

    // E: start in ERR re-arms, then reset mid-dump
    new_run(); push_dump();
    pulse_start();
    chk("E_timeout_clr", timeout, 0);
    chk("E_halted_clr", halted, 0);
    chk("E_counts_clr", |cycle_count, 0);
    chk("E_busy", busy, 1);
    drive_run(2, 2, 2, 2, 3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt >= 3) break;
    end
    chk("E_words_before_reset", acc_cnt >= 3, 1);
    @(posedge clk); #3 reset = 1'b0;
    #1 chk_idle("E_rst_mid");
    sb_q.delete();
    @(negedge clk); @(negedge clk) reset = 1'b1;

    // F: clean run after reset
    new_run(); push_dump();
    pulse_start();
    drive_run(1, 4, 7, 10, 11);
    rd_latency("F_rd_latency");
    wait_done("F_done");
    chk_counts("F", 1, 4, 7, 10, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
